// File: rtl/delay_sequencer_pkg.sv
// Shared types and widths for the DAC delay sequencer and the delay RAM it reads.
// Widths here must match the delay RAM port B geometry.
package delay_sequencer_pkg;

  localparam int SEQ_ADDR_W  = 11;
  localparam int SEQ_DELAY_W = 24;
  // Wide enough for the full legal read-latency range 1..7.
  localparam int LAT_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    COUNT,
    FIRE
  } state_t;

endpackage

// File: rtl/delay_sequencer_down_counter.sv
// Loadable delay countdown with a zero flag; clear wins over load, load wins over decrement.
// Saturates at zero so a stray decrement can never wrap to the maximum delay.
module delay_sequencer_down_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/delay_sequencer.sv
// Per-DAC-channel delay sequencer: looks up a wave's delay word, counts it down, pulses fire.
// Fire lands RD_LATENCY+1+D cycles after the start edge; one request can wait in the pending slot.
module delay_sequencer
  import delay_sequencer_pkg::*;
#(
  parameter int ADDR_W     = SEQ_ADDR_W,
  parameter int DELAY_W    = SEQ_DELAY_W,
  parameter int RD_LATENCY = 2
) (
  input  logic               I_DELY_CLK,
  input  logic               I_Rst_n,
  input  logic               I_START,
  input  logic [ADDR_W-1:0]  I_WAVE_ID,
  input  logic               I_ABORT,
  output logic [ADDR_W-1:0]  O_READ_ADDR,
  input  logic [DELAY_W-1:0] I_DELAY,
  output logic               O_READY,
  output logic               O_BUSY,
  output logic               O_FIRE,
  output logic [ADDR_W-1:0]  O_FIRE_WAVE_ID,
  output logic               O_OVERFLOW
);

  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LATENCY);

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [ADDR_W-1:0]  active_id;
  logic [ADDR_W-1:0]  read_addr;
  logic [ADDR_W-1:0]  pend_id;
  logic [ADDR_W-1:0]  launch_id;
  logic               pend_vld;
  logic               overflow;
  logic               cnt_zero;
  logic               cnt_load;
  logic               cnt_dec;
  logic               firing;

  // The RAM word is only trusted on the last FETCH cycle; earlier it may belong to the old address.
  assign cnt_load  = !I_ABORT && (state == FETCH) && (lat_cnt == LAT_W'(1));
  assign cnt_dec   = !I_ABORT && (state == COUNT) && !cnt_zero;
  assign launch_id = pend_vld ? pend_id : I_WAVE_ID;

  delay_sequencer_down_counter #(
    .W (DELAY_W)
  ) u_dly_cnt (
    .clk      (I_DELY_CLK),
    .rst_n    (I_Rst_n),
    .clr      (I_ABORT),
    .load     (cnt_load),
    .load_val (I_DELAY),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge I_DELY_CLK or negedge I_Rst_n) begin
    if (!I_Rst_n) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      active_id <= '0;
      read_addr <= '0;
      pend_id   <= '0;
      pend_vld  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (I_ABORT) begin
        // Abort swallows any same-cycle start silently; the read address is left as is.
        state    <= IDLE;
        lat_cnt  <= '0;
        pend_id  <= '0;
        pend_vld <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (I_START) begin
              active_id <= I_WAVE_ID;
              read_addr <= I_WAVE_ID;
              lat_cnt   <= LAT_INIT;
              state     <= FETCH;
            end
          end
          FETCH: begin
            lat_cnt <= lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) begin
              state <= COUNT;
            end
          end
          COUNT: begin
            if (cnt_zero) begin
              state <= FIRE;
            end
          end
          FIRE: begin
            // A start into an empty slot is promoted straight to FETCH; into a full one it is dropped.
            if (pend_vld || I_START) begin
              active_id <= launch_id;
              read_addr <= launch_id;
              lat_cnt   <= LAT_INIT;
              pend_vld  <= 1'b0;
              state     <= FETCH;
              if (pend_vld && I_START) begin
                overflow <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase

        if (I_START && ((state == FETCH) || (state == COUNT))) begin
          if (pend_vld) begin
            overflow <= 1'b1;
          end else begin
            pend_vld <= 1'b1;
            pend_id  <= I_WAVE_ID;
          end
        end
      end
    end
  end

  // Fire is gated by abort combinationally so an abort in the FIRE cycle itself suppresses it.
  assign firing         = (state == FIRE) && !I_ABORT;
  assign O_FIRE         = firing;
  assign O_FIRE_WAVE_ID = firing ? active_id : '0;
  assign O_READ_ADDR    = read_addr;
  assign O_READY        = !pend_vld;
  assign O_BUSY         = (state != IDLE);
  assign O_OVERFLOW     = overflow;

endmodule

// File: tb/tb_delay_sequencer.sv
// Directed bench for delay_sequencer with a two-stage (address reg + output reg) delay RAM model.
module tb_delay_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [10:0] wave_id;
  logic        abort;
  logic [10:0] read_addr;
  logic [23:0] delay;
  logic        ready;
  logic        busy;
  logic        fire;
  logic [10:0] fire_id;
  logic        overflow;

  logic [23:0] ram [0:2047];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [10:0] id;
    logic [23:0] dly;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  delay_sequencer #(
    .ADDR_W     (11),
    .DELAY_W    (24),
    .RD_LATENCY (2)
  ) dut (
    .I_DELY_CLK     (clk),
    .I_Rst_n        (rst_n),
    .I_START        (start),
    .I_WAVE_ID      (wave_id),
    .I_ABORT        (abort),
    .O_READ_ADDR    (read_addr),
    .I_DELAY        (delay),
    .O_READY        (ready),
    .O_BUSY         (busy),
    .O_FIRE         (fire),
    .O_FIRE_WAVE_ID (fire_id),
    .O_OVERFLOW     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT registers the address; the RAM output register adds the second cycle.
  always @(posedge clk) delay <= ram[read_addr];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_fire(input int budget, output int n, output logic hit);
    n   = 0;
    hit = 1'b0;
    while (n < budget && !hit) begin
      tick();
      n++;
      if (fire) hit = 1'b1;
    end
  endtask

  task automatic start_req(input logic [10:0] id);
    start   = 1'b1;
    wave_id = id;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    int   n;
    int   fires;
    logic hit;

    for (int i = 0; i < 2048; i++) ram[i] = 24'd0;
    vecs[0] = '{id: 11'd3,    dly: 24'd5,  exp_lat: 8};
    vecs[1] = '{id: 11'd7,    dly: 24'd0,  exp_lat: 3};
    vecs[2] = '{id: 11'd12,   dly: 24'd1,  exp_lat: 4};
    vecs[3] = '{id: 11'd100,  dly: 24'd20, exp_lat: 23};
    vecs[4] = '{id: 11'd2047, dly: 24'd2,  exp_lat: 5};

    rst_n = 1'b0; start = 1'b0; wave_id = '0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_fire", fire, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_addr", read_addr, 0);
    chk("rst_fire_id", fire_id, 0);
    rst_n = 1'b1;
    tick();

    // Single requests: latency, address, fire id and clean return to idle.
    for (int v = 0; v < 5; v++) begin
      ram[vecs[v].id] = vecs[v].dly;
      start_req(vecs[v].id);
      chk("vec_addr", read_addr, vecs[v].id);
      chk("vec_busy", busy, 1);
      wait_fire(vecs[v].exp_lat + 10, n, hit);
      chk("vec_fire_seen", hit, 1);
      chk("vec_latency", n, vecs[v].exp_lat);
      chk("vec_fire_id", fire_id, vecs[v].id);
      tick();
      chk("vec_pulse_end", fire, 0);
      chk("vec_idle", busy, 0);
      chk("vec_ready", ready, 1);
    end

    // Queue one, drop the next; fires in order, second 8 cycles after the first.
    ram[1] = 24'd10; ram[2] = 24'd4; ram[9] = 24'd1;
    start_req(11'd1);
    start = 1'b1; wave_id = 11'd2;
    tick();
    chk("q_ready_low", ready, 0);
    wave_id = 11'd9;
    tick();
    start = 1'b0;
    chk("q_overflow", overflow, 1);
    tick();
    chk("q_overflow_end", overflow, 0);
    wait_fire(30, n, hit);
    chk("q_fire1_lat", n, 10);
    chk("q_fire1_id", fire_id, 1);
    wait_fire(20, n, hit);
    chk("q_fire2_lat", n, 8);
    chk("q_fire2_id", fire_id, 2);
    tick();
    chk("q_idle", busy, 0);
    wait_fire(20, n, hit);
    chk("q_no_third", hit, 0);

    // Abort mid-COUNT with a pending entry.
    ram[20] = 24'd30; ram[21] = 24'd2;
    start_req(11'd20);
    start_req(11'd21);
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_ready", ready, 1);
    chk("ab_busy", busy, 0);
    fires = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (fire) fires++;
    end
    chk("ab_no_fire", fires, 0);
    chk("ab_addr_hold", read_addr, 20);
    start_req(11'd3);
    wait_fire(20, n, hit);
    chk("ab_fresh_lat", n, 8);
    chk("ab_fresh_id", fire_id, 3);
    tick();

    // Abort plus start in the FIRE cycle.
    ram[4] = 24'd2; ram[5] = 24'd1;
    start_req(11'd4);
    wait_fire(15, n, hit);
    chk("af_fire_before", fire, 1);
    abort = 1'b1; start = 1'b1; wave_id = 11'd5;
    #1;
    chk("af_fire_suppressed", fire, 0);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("af_overflow", overflow, 0);
    chk("af_busy", busy, 0);
    chk("af_ready", ready, 1);
    wait_fire(15, n, hit);
    chk("af_not_accepted", hit, 0);

    // Start in FIRE with empty slot is promoted straight to FETCH.
    ram[6] = 24'd1; ram[8] = 24'd3;
    start_req(11'd6);
    wait_fire(15, n, hit);
    chk("pr_fire1_lat", n, 4);
    start_req(11'd8);
    chk("pr_addr", read_addr, 8);
    chk("pr_ready", ready, 1);
    chk("pr_busy", busy, 1);
    wait_fire(20, n, hit);
    chk("pr_fire2_lat", n, 6);
    chk("pr_fire2_id", fire_id, 8);
    tick();

    // Start in FIRE with slot full is dropped.
    ram[10] = 24'd3; ram[11] = 24'd0; ram[12] = 24'd2;
    start_req(11'd10);
    start_req(11'd11);
    wait_fire(15, n, hit);
    chk("fo_fire1_lat", n, 5);
    chk("fo_fire1_id", fire_id, 10);
    start_req(11'd12);
    chk("fo_overflow", overflow, 1);
    chk("fo_addr", read_addr, 11);
    wait_fire(15, n, hit);
    chk("fo_fire2_lat", n, 3);
    chk("fo_fire2_id", fire_id, 11);
    tick();
    chk("fo_overflow_end", overflow, 0);
    chk("fo_idle", busy, 0);
    wait_fire(15, n, hit);
    chk("fo_no_third", hit, 0);

    // Maximum delay, then asynchronous reset mid-count.
    ram[30] = 24'hFFFFFF;
    start_req(11'd30);
    fires = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fire) fires++;
    end
    chk("mx_no_early_fire", fires, 0);
    chk("mx_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mx_rst_ready", ready, 1);
    chk("mx_rst_busy", busy, 0);
    chk("mx_rst_fire", fire, 0);
    chk("mx_rst_addr", read_addr, 0);
    chk("mx_rst_fire_id", fire_id, 0);
    chk("mx_rst_overflow", overflow, 0);
    #3;
    rst_n = 1'b1;
    wait_fire(30, n, hit);
    chk("mx_no_fire_after", hit, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
